// File: rtl/mux_scan_pkg.sv
// Shared definitions for the 4:1 mux scan controller.
// Holds the FSM state encoding, channel/data widths, the settle-count
// limits and a helper that folds the SETTLE_CYC parameter into the
// counter width.
package mux_scan_pkg;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned CH_W       = 2;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef logic [CH_W-1:0]   ch_t;
  typedef logic [NUM_CH-1:0] scan_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // Keeps an out-of-range settle count inside the legal window.
  function automatic cnt_t clamp_settle(input int unsigned v);
    if (v < SETTLE_MIN) return CNT_W'(SETTLE_MIN);
    if (v > SETTLE_MAX) return CNT_W'(SETTLE_MAX);
    return CNT_W'(v);
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scan controller and its environment.
// start/cont/abort : scan control requests
// s                : select to the downstream 4:1 mux
// y                : mux output returned to the controller
// data/valid       : last completed scan and its one-cycle update strobe
// busy             : scan in progress (SETTLE or SAMPLE)
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic  start;
  logic  cont;
  logic  abort;
  ch_t   s;
  logic  y;
  scan_t data;
  logic  valid;
  logic  busy;

  modport slave (
    input  start, cont, abort, y,
    output s, data, valid, busy
  );

  modport master (
    output start, cont, abort, y,
    input  s, data, valid, busy
  );

endinterface

// File: rtl/mux_settle_timer.sv
// Settle down-counter.
// clk, rst : clock and synchronous active-high reset
// load     : reload the counter with load_val
// load_val : settle cycles to count
// expired  : high while the count is at its last cycle (count == 1)
module mux_settle_timer
  import mux_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  cnt_t load_val,
  output logic expired
);

  cnt_t cnt_q;

  // expired is registered by predicting the count one cycle ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else if (load) begin
      cnt_q   <= load_val;
      expired <= (load_val == CNT_W'(1));
    end else if (cnt_q != '0) begin
      cnt_q   <= cnt_q - CNT_W'(1);
      expired <= (cnt_q == CNT_W'(2));
    end else begin
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the four inputs of an external 4:1 mux: drives the select s,
// waits SETTLE_CYC cycles, samples y into a shadow register per channel,
// then publishes the shadow to data with a one-cycle valid strobe.
// clk, rst : clock and synchronous active-high reset
// bus      : slave side of mux_scan_ctrl_if (start/cont/abort/y in,
//            s/data/valid/busy out, all outputs registered)
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  mux_scan_ctrl_if.slave  bus
);

  localparam cnt_t SETTLE_LD = clamp_settle(SETTLE_CYC);
  localparam ch_t  LAST_CH   = CH_W'(NUM_CH - 1);

  state_t state_q, state_d;
  ch_t    ch_q, ch_d;
  ch_t    s_q, s_d;
  scan_t  shadow_q, shadow_d;
  scan_t  data_q, data_d;
  logic   valid_q, valid_d;
  logic   busy_q, busy_d;
  logic   load_c;
  logic   expired;

  mux_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .load_val (SETTLE_LD),
    .expired  (expired)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      s_q      <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      s_q      <= s_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and next-output logic; abort overrides everything below it.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    s_d      = s_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    load_c   = 1'b0;

    if (bus.abort) begin
      state_d  = ST_IDLE;
      ch_d     = '0;
      s_d      = '0;
      shadow_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          s_d = '0;
          if (bus.start) begin
            state_d = ST_SETTLE;
            ch_d    = '0;
            load_c  = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (expired) state_d = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          shadow_d[ch_q] = bus.y;
          if (ch_q != LAST_CH) begin
            ch_d    = ch_q + CH_W'(1);
            s_d     = ch_q + CH_W'(1);
            load_c  = 1'b1;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          data_d  = shadow_q;
          valid_d = 1'b1;
          ch_d    = '0;
          s_d     = '0;
          if (bus.cont) begin
            state_d = ST_SETTLE;
            load_c  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
  end

  assign bus.s     = s_q;
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE_CYC 1 and 3) share the
// control inputs, each sees its own registered 4:1 mux model. A timing
// model derived from scan positions predicts outputs; completed scans are
// queued and matched when the DUT raises valid.
module tb_mux_scan_ctrl;

  localparam int SET0 = 1;
  localparam int SET1 = 3;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       cont  = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] i_drv = 4'b0000;

  always #5 clk = ~clk;

  mux_scan_ctrl_if bus0 ();
  mux_scan_ctrl_if bus1 ();

  assign bus0.start = start;
  assign bus0.cont  = cont;
  assign bus0.abort = abort;
  assign bus1.start = start;
  assign bus1.cont  = cont;
  assign bus1.abort = abort;

  mux_scan_ctrl #(.SETTLE_CYC(SET0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mux_scan_ctrl #(.SETTLE_CYC(SET1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Downstream mux: y follows the selected input one cycle after s.
  always @(posedge clk) begin
    bus0.y <= i_drv[bus0.s];
    bus1.y <= i_drv[bus1.s];
  end

  typedef struct {
    int         t0;
    logic [3:0] data;
  } sb_t;

  sb_t        sb0[$];
  sb_t        sb1[$];
  logic [3:0] i_hist[$];
  int         edge_cnt = 0;
  int         checks   = 0;
  int         errors   = 0;

  int         act[2];
  int         t0[2];
  logic [1:0] exp_s[2];
  logic       exp_busy[2];
  logic       exp_valid[2];
  logic [3:0] exp_data[2];

  function automatic int set_of(input int d);
    return (d == 0) ? SET0 : SET1;
  endfunction

  task automatic chk(input string name, input int d, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s dut%0d edge=%0d actual=%0h required=%0h", name, d, edge_cnt, actual, expected);
    end
  endtask

  // Reference model: a scan accepted at edge t0 shows channel q/(S+1)
  // for 4*(S+1) edges, one DONE edge, and publishes at edge t0+4*(S+1)+1.
  // Channel k captures the mux input latched at edge t0+(k+1)*(S+1)-1.
  initial begin
    int         st, len, q;
    logic [3:0] cap;
    sb_t        e;
    act = '{0, 0};
    t0  = '{0, 0};
    forever begin
      @(posedge clk);
      i_hist.push_back(i_drv);
      for (int d = 0; d < 2; d++) begin
        st = set_of(d);
        len = 4 * (st + 1) + 1;
        exp_valid[d] = 1'b0;
        if (rst) begin
          act[d] = 0;
          exp_data[d] = 4'b0000;
        end else if (abort) begin
          act[d] = 0;
        end else if (act[d] != 0) begin
          q = edge_cnt - t0[d];
          if (q == len) begin
            for (int k = 0; k < 4; k++) cap[k] = i_hist[t0[d] + (k + 1) * (st + 1) - 1][k];
            exp_data[d]  = cap;
            exp_valid[d] = 1'b1;
            e.t0 = t0[d];
            e.data = cap;
            if (d == 0) sb0.push_back(e); else sb1.push_back(e);
            if (cont) t0[d] = edge_cnt; else act[d] = 0;
          end
        end else if (start) begin
          act[d] = 1;
          t0[d] = edge_cnt;
        end
        if (act[d] != 0) begin
          q = edge_cnt - t0[d];
          if (q < 4 * (st + 1)) begin
            exp_s[d]    = 2'(q / (st + 1));
            exp_busy[d] = 1'b1;
          end else begin
            exp_s[d]    = 2'd3;
            exp_busy[d] = 1'b0;
          end
        end else begin
          exp_s[d]    = 2'd0;
          exp_busy[d] = 1'b0;
        end
      end
      edge_cnt++;
    end
  end

  // Monitor: per-cycle output checks plus scoreboard pop on every valid.
  initial begin
    logic [1:0] ds;
    logic       db, dv;
    logic [3:0] dd;
    sb_t        e;
    int         nonempty;
    forever begin
      @(negedge clk);
      if (edge_cnt > 0) begin
        for (int d = 0; d < 2; d++) begin
          if (d == 0) begin
            ds = bus0.s; db = bus0.busy; dv = bus0.valid; dd = bus0.data;
          end else begin
            ds = bus1.s; db = bus1.busy; dv = bus1.valid; dd = bus1.data;
          end
          chk("s", d, int'(ds), int'(exp_s[d]));
          chk("busy", d, int'(db), int'(exp_busy[d]));
          chk("valid", d, int'(dv), int'(exp_valid[d]));
          chk("data", d, int'(dd), int'(exp_data[d]));
          if (dv) begin
            nonempty = (d == 0) ? int'(sb0.size() > 0) : int'(sb1.size() > 0);
            chk("sb_pending", d, nonempty, 1);
            if (nonempty != 0) begin
              e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
              chk("sb_data", d, int'(dd), int'(e.data));
              chk("sb_latency", d, edge_cnt - 1 - e.t0, 4 * (set_of(d) + 1) + 1);
            end
          end
        end
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  initial begin
    wait_n(3);
    rst = 1'b0;
    wait_n(2);

    // Single scans with fixed patterns.
    i_drv = 4'b1010; pulse_start(); wait_n(20);
    i_drv = 4'b0110; pulse_start(); wait_n(20);

    // Continuous mode, pattern changed between scans.
    i_drv = 4'b0001; cont = 1'b1; pulse_start();
    wait_n(9); i_drv = 4'b1110;
    wait_n(12); cont = 1'b0;
    wait_n(40);

    // Abort in cycle 5 of a scan.
    i_drv = 4'b0101; pulse_start(); wait_n(4);
    abort = 1'b1; wait_n(1); abort = 1'b0;
    wait_n(25);

    // Reset during SETTLE of channel 2, then a fresh scan.
    i_drv = 4'b1100; pulse_start(); wait_n(4);
    rst = 1'b1; wait_n(1); rst = 1'b0;
    i_drv = 4'b1001; pulse_start(); wait_n(25);

    // Start pulses while busy.
    i_drv = 4'b0011; pulse_start();
    repeat (3) begin wait_n(1); pulse_start(); end
    wait_n(30);

    // Abort while in DONE.
    i_drv = 4'b0111; pulse_start(); wait_n(8);
    abort = 1'b1; wait_n(1); abort = 1'b0;
    wait_n(25);

    // Randomized traffic.
    repeat (800) begin
      @(negedge clk);
      start = ($urandom % 4 == 0);
      abort = ($urandom % 40 == 0);
      rst   = ($urandom % 150 == 0);
      if ($urandom % 16 == 0) cont = ~cont;
      if ($urandom % 3 == 0) i_drv = 4'($urandom);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; rst = 1'b0; cont = 1'b0;
    wait_n(50);

    chk("sb_drain", 0, sb0.size(), 0);
    chk("sb_drain", 1, sb1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1, settle cycles after each select change before y is sampled; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request one scan of channels 0..3; sampled only in IDLE.
REQ-005 SHALL have port cont, input, 1, continuous mode; sampled at end of each scan.
REQ-006 SHALL have port abort, input, 1, cancel scan in progress.
REQ-007 SHALL have port s, output, 2, select driven to the downstream 4:1 mux.
REQ-008 SHALL have port y, input, 1, mux output returned from the 4:1 mux.
REQ-009 SHALL have port data, output, 4, last completed scan; data[k] = y sampled with s=k.
REQ-010 SHALL have port valid, output, 1, one-cycle pulse when data updates.
REQ-011 SHALL have port busy, output, 1, high in SETTLE or SAMPLE.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-013 SHALL move IDLE->SETTLE on start=1; s=0, channel counter ch=0, settle counter loaded with SETTLE_CYC.
REQ-014 SHALL stay in SETTLE for exactly SETTLE_CYC cycles, decrementing; counter 1 -> SAMPLE.
REQ-015 SHALL in SAMPLE write y into shadow bit ch.
- ch<3: ch+1, s=ch+1, reload counter, ->SETTLE.
- ch=3: ->DONE.
REQ-016 SHALL in DONE copy shadow to data and assert valid for that cycle only.
REQ-017 SHALL leave DONE as follows:
- cont=1: ->SETTLE with ch=0, s=0.
- cont=0: ->IDLE.
REQ-018 SHALL hold s at 0 in IDLE; s changes only on SETTLE entry.
REQ-019 SHALL give latency from start-sampled cycle to valid of 4*(SETTLE_CYC+1)+1 cycles (9 at default).
REQ-020 SHALL ignore start when not in IDLE; no queuing.
REQ-021 SHALL give abort priority over start, cont and counters: ->IDLE next cycle, s=0, no valid, data unchanged, shadow discarded.
REQ-022 SHALL give abort in DONE priority over the data update: data keeps its old value and valid stays 0.
REQ-023 SHALL wrap ch only via DONE; ch never exceeds 3.

Reset
REQ-024 SHALL on rst=1 at a clock edge force IDLE, s=0, ch=0, counter=0, shadow=0, data=0, valid=0, busy=0, regardless of state.
REQ-025 SHALL give rst priority over abort and start; start with rst is lost.

Structure
REQ-026 SHALL place the state encoding (2-bit), channel width and SETTLE_CYC limits in shared package mux_scan_pkg.
REQ-027 SHALL put the settle down-counter in sub-module mux_settle_timer: inputs load and load value, output expired.
REQ-028 SHALL keep all outputs registered; no combinational path from y to any output.

Verification
REQ-029 SHALL cover default scan: mux model i=4'b1010, start pulse at cycle 0 -> s sequence 0,0,1,1,2,2,3,3; valid at cycle 9; data=4'b1010.
REQ-030 SHALL cover SETTLE_CYC=3, i=4'b0110: y changes 1 cycle after s -> data=4'b0110; valid at cycle 17.
REQ-031 SHALL cover cont=1, i toggled from 4'b0001 to 4'b1110 between scans -> consecutive valids 9 cycles apart; data 4'b0001 then 4'b1110.
REQ-032 SHALL cover abort in cycle 5 of a scan -> IDLE next cycle, no valid, data keeps prior value, s=0.
REQ-033 SHALL cover rst asserted mid-SETTLE for ch=2 -> next cycle all outputs 0; fresh start then gives a correct scan.
REQ-034 SHALL cover start pulses while busy -> ignored, exactly one valid per accepted start.
